// File: rtl/axi_mem_pkg.sv
// Shared types for axi_mem_slave: AXI burst encodings, response codes and FSM states.
package axi_mem_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Beat address generator: next address, word index, range check and burst legality.
// WRAP bursts are only legal when AXI_MEM_WRAP_EN is defined.
module axi_mem_addr_gen #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic [31:0]      addr,
   input  logic [7:0]       len,
   input  logic [2:0]       size,
   input  logic [1:0]       burst,
   output logic [31:0]      next_addr,
   output logic [IDX_W-1:0] word_idx,
   output logic             in_range,
   output logic             burst_err
);
   import axi_mem_pkg::*;

   logic [32:0] diff;
   logic [31:0] offset;
   logic [31:0] step;
   logic [31:0] size_mask;
   logic        wrap_ok;
   logic        unused_bits;

   // Bit 32 is the borrow, so addresses below BASE_ADDR fall out of range.
   assign diff      = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign offset    = diff[31:0];
   assign word_idx  = offset[3 +: IDX_W];
   assign in_range  = !diff[32] && ({3'b000, offset[31:3]} < 32'(DEPTH_WORDS));
   assign step      = 32'd1 << size;
   assign size_mask = step - 32'd1;

`ifdef AXI_MEM_WRAP_EN
   logic [31:0] wrap_mask;
   assign wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
   assign wrap_ok   = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
                      ((addr & size_mask) == 32'd0);
`else
   assign wrap_ok   = 1'b0;
`endif

   always_comb begin
      // NOTE: default first, so every path through the case assigns next_addr and no latch is inferred.
      next_addr = addr;
      case (burst_e'(burst))
         BURST_INCR: next_addr = addr + step;
`ifdef AXI_MEM_WRAP_EN
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
`endif
         default:    next_addr = addr;
      endcase
   end

   assign burst_err = (size > 3'd3) || (burst == BURST_RSVD) ||
                      ((burst == BURST_WRAP) && !wrap_ok);

   assign unused_bits = ^{offset[2:0], len, size_mask};

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: 64-bit byte-writable array with independent write and read FSMs.
// Define AXI_MEM_WRAP_EN to support WRAP bursts; otherwise they complete with SLVERR.
module axi_mem_slave #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic [3:0]  awqos,
   input  logic [3:0]  awregion,
   input  logic        awvalid,
   output logic        awready,
   input  logic [63:0] wdata,
   input  logic [7:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic        bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic        arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic [3:0]  arqos,
   input  logic [3:0]  arregion,
   input  logic        arvalid,
   output logic        arready,
   output logic        rid,
   output logic [63:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready
);
   import axi_mem_pkg::*;

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [63:0] mem [DEPTH_WORDS];

   wr_state_e   w_state_q, w_state_d;
   logic        w_id_q, w_id_d, w_skip_q, w_skip_d, w_err_q, w_err_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [2:0]  w_size_q, w_size_d;
   logic [1:0]  w_burst_q, w_burst_d;
   logic        mem_we;

   rd_state_e   r_state_q, r_state_d;
   logic        r_id_q, r_id_d, r_skip_q, r_skip_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [2:0]  r_size_q, r_size_d;
   logic [1:0]  r_burst_q, r_burst_d, rresp_q, rresp_d;
   logic [63:0] rdata_q, rdata_d;
   logic        rd_beat_ok;

   logic [31:0]      wg_next, rg_next;
   logic [IDX_W-1:0] wg_idx, rg_idx;
   logic             wg_in_range, wg_burst_err, rg_in_range, rg_burst_err;
   logic             unused_sideband;

   assign unused_sideband = ^{awlock, awcache, awprot, awqos, awregion,
                              arlock, arcache, arprot, arqos, arregion};

   // While idle each generator sees the incoming request so legality is judged at the handshake.
   axi_mem_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_wr_gen (
      .addr      ((w_state_q == W_IDLE) ? awaddr  : w_addr_q),
      .len       ((w_state_q == W_IDLE) ? awlen   : w_len_q),
      .size      ((w_state_q == W_IDLE) ? awsize  : w_size_q),
      .burst     ((w_state_q == W_IDLE) ? awburst : w_burst_q),
      .next_addr (wg_next),
      .word_idx  (wg_idx),
      .in_range  (wg_in_range),
      .burst_err (wg_burst_err)
   );

   // In R_DATA r_addr_q already holds the address of the beat after the one on the bus.
   axi_mem_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_rd_gen (
      .addr      ((r_state_q == R_IDLE) ? araddr  : r_addr_q),
      .len       ((r_state_q == R_IDLE) ? arlen   : r_len_q),
      .size      ((r_state_q == R_IDLE) ? arsize  : r_size_q),
      .burst     ((r_state_q == R_IDLE) ? arburst : r_burst_q),
      .next_addr (rg_next),
      .word_idx  (rg_idx),
      .in_range  (rg_in_range),
      .burst_err (rg_burst_err)
   );

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cnt_d   = w_cnt_q;
      w_skip_d  = w_skip_q;
      w_err_d   = w_err_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (awvalid) begin
            w_state_d = W_DATA;
            w_id_d    = awid;
            w_addr_d  = awaddr;
            w_len_d   = awlen;
            w_size_d  = awsize;
            w_burst_d = awburst;
            w_cnt_d   = 8'd0;
            w_skip_d  = wg_burst_err;
            w_err_d   = wg_burst_err;
         end
         W_DATA: if (wvalid) begin
            mem_we   = !w_skip_q && wg_in_range;
            w_err_d  = w_err_q || !wg_in_range;
            w_addr_d = wg_next;
            w_cnt_d  = w_cnt_q + 8'd1;
            if (wlast || (w_cnt_q == w_len_q)) w_state_d = W_RESP;
         end
         W_RESP: if (bready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   assign rd_beat_ok = rg_in_range && !((r_state_q == R_IDLE) ? rg_burst_err : r_skip_q);

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_cnt_d   = r_cnt_q;
      r_skip_d  = r_skip_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (r_state_q == R_IDLE) begin
         if (arvalid) begin
            r_state_d = R_DATA;
            r_id_d    = arid;
            r_addr_d  = rg_next;
            r_len_d   = arlen;
            r_size_d  = arsize;
            r_burst_d = arburst;
            r_cnt_d   = 8'd0;
            r_skip_d  = rg_burst_err;
            rdata_d   = rd_beat_ok ? mem[rg_idx] : 64'd0;
            rresp_d   = rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end else if (rready) begin
         if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
         end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = rg_next;
            rdata_d  = rd_beat_ok ? mem[rg_idx] : 64'd0;
            rresp_d  = rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values regardless of order.
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= 1'b0;
         w_addr_q  <= 32'd0;
         w_len_q   <= 8'd0;
         w_size_q  <= 3'd0;
         w_burst_q <= 2'd0;
         w_cnt_q   <= 8'd0;
         w_skip_q  <= 1'b0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_id_q    <= 1'b0;
         r_addr_q  <= 32'd0;
         r_len_q   <= 8'd0;
         r_size_q  <= 3'd0;
         r_burst_q <= 2'd0;
         r_cnt_q   <= 8'd0;
         r_skip_q  <= 1'b0;
         rdata_q   <= 64'd0;
         rresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cnt_q   <= w_cnt_d;
         w_skip_q  <= w_skip_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_cnt_q   <= r_cnt_d;
         r_skip_q  <= r_skip_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // NOTE: the array has no reset branch: contents survive rst and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) mem[wg_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign awready = (w_state_q == W_IDLE);
   assign wready  = (w_state_q == W_DATA);
   assign bvalid  = (w_state_q == W_RESP);
   assign bid     = w_id_q;
   assign bresp   = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

   assign arready = (r_state_q == R_IDLE);
   assign rvalid  = (r_state_q == R_DATA);
   assign rlast   = rvalid && (r_cnt_q == r_len_q);
   assign rid     = r_id_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected B/R responses, a monitor checks them.
// Expectations for WRAP bursts follow AXI_MEM_WRAP_EN.
module tb_axi_mem_slave;
   import axi_mem_pkg::*;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic        awid, awlock, awvalid, awready;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen, wstrb;
   logic [2:0]  awsize, awprot, arsize, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion;
   logic [63:0] wdata, rdata;
   logic        wlast, wvalid, wready, bid, bvalid, bready;
   logic        arid, arlock, arvalid, arready, rid, rlast, rvalid, rready;

   typedef struct {logic id; logic [1:0] resp;} b_exp_t;
   typedef struct {logic [63:0] data; logic [1:0] resp; logic last; logic id;} r_exp_t;
   b_exp_t b_q[$];
   r_exp_t r_q[$];

   int tests = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queue head; pops on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (bvalid) begin
               if (b_q.size() == 0) check("b_unexpected", bvalid, 1'b0);
               else begin
                  check("bresp", bresp, b_q[0].resp);
                  check("bid", bid, b_q[0].id);
                  if (bready) void'(b_q.pop_front());
               end
            end
            if (rvalid) begin
               if (r_q.size() == 0) check("r_unexpected", rvalid, 1'b0);
               else begin
                  check("rdata", rdata, r_q[0].data);
                  check("rresp", rresp, r_q[0].resp);
                  check("rlast", rlast, r_q[0].last);
                  check("rid", rid, r_q[0].id);
                  if (rready) void'(r_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ch: 0=AW, 1=W, 2=AR. Returns just after the edge on which the handshake happened.
   task automatic handshake(input int ch);
      logic ok;
      for (int n = 0; n < 200; n++) begin
         case (ch)
            0:       ok = awready;
            1:       ok = wready;
            default: ok = arready;
         endcase
         tick();
         if (ok) return;
      end
      tests++;
      failures++;
      $display("FAIL handshake_timeout ch=%0d: ready not seen in 200 cycles, required ready=1", ch);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic id, input logic [63:0] base,
                            input logic [7:0] strb, input logic [1:0] resp);
      b_q.push_back('{id: id, resp: resp});
      awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
      handshake(0);
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wdata = base + 64'(i); wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
         handshake(1);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id);
      araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
      handshake(2);
      arvalid = 1'b0;
   endtask

   task automatic exp_r(input logic [63:0] data, input logic [1:0] resp, input logic last, input logic id);
      r_q.push_back('{data: data, resp: resp, last: last, id: id});
   endtask

   task automatic drain();
      for (int n = 0; n < 2000; n++) begin
         if (b_q.size() == 0 && r_q.size() == 0) return;
         tick();
      end
      tests++;
      failures++;
      $display("FAIL drain_timeout: %0d B and %0d R responses outstanding, required 0", b_q.size(), r_q.size());
      b_q.delete();
      r_q.delete();
   endtask

   initial begin
      rst = 1'b1; bready = 1'b1; rready = 1'b1;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
      awlock = 0; awcache = 0; awprot = 0; awqos = 0; awregion = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0;
      arlock = 0; arcache = 0; arprot = 0; arqos = 0; arregion = 0;
      repeat (3) tick();

      check("rst_awready", awready, 1'b1);
      check("rst_arready", arready, 1'b1);
      check("rst_wready", wready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rlast", rlast, 1'b0);
      check("rst_bresp", bresp, 2'b00);
      check("rst_rresp", rresp, 2'b00);
      check("rst_bid", bid, 1'b0);
      check("rst_rid", rid, 1'b0);
      check("rst_rdata", rdata, 64'd0);
      rst = 1'b0;
      tick();

      axi_write(32'h00, 8'd0, BURST_INCR, 3'd3, 1'b0, 64'hA0A0, 8'hFF, RESP_OKAY);
      axi_write(32'h08, 8'd0, BURST_INCR, 3'd3, 1'b0, 64'h0, 8'hFF, RESP_OKAY);
      drain();

      // 4-beat INCR write and read-back
      axi_write(32'h10, 8'd3, BURST_INCR, 3'd3, 1'b1, 64'd1, 8'hFF, RESP_OKAY);
      drain();
      for (int i = 0; i < 4; i++) exp_r(64'(i + 1), RESP_OKAY, i == 3, 1'b1);
      axi_read(32'h10, 8'd3, BURST_INCR, 3'd3, 1'b1);
      drain();

      // Partial strobe over a zero word
      axi_write(32'h08, 8'd0, BURST_INCR, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, RESP_OKAY);
      drain();
      exp_r(64'h0000_0000_FFFF_FFFF, RESP_OKAY, 1'b1, 1'b0);
      axi_read(32'h08, 8'd0, BURST_INCR, 3'd3, 1'b0);
      drain();

      // Out of range, reserved burst and oversize transfers; word 0 must be untouched
      exp_r(64'd0, RESP_SLVERR, 1'b0, 1'b1);
      exp_r(64'd0, RESP_SLVERR, 1'b1, 1'b1);
      axi_read(32'(DEPTH * 8), 8'd1, BURST_INCR, 3'd3, 1'b1);
      drain();
      axi_write(32'(DEPTH * 8), 8'd0, BURST_INCR, 3'd3, 1'b0, 64'h1234, 8'hFF, RESP_SLVERR);
      axi_write(32'h00, 8'd0, BURST_RSVD, 3'd3, 1'b1, 64'hDEAD, 8'hFF, RESP_SLVERR);
      drain();
      exp_r(64'hA0A0, RESP_OKAY, 1'b1, 1'b0);
      axi_read(32'h00, 8'd0, BURST_INCR, 3'd3, 1'b0);
      exp_r(64'd0, RESP_SLVERR, 1'b1, 1'b0);
      axi_read(32'h00, 8'd0, BURST_INCR, 3'd4, 1'b0);
      drain();

      // R back-pressure for 5 cycles on beat 1
      for (int i = 0; i < 4; i++) exp_r(64'(i + 1), RESP_OKAY, i == 3, 1'b0);
      axi_read(32'h10, 8'd3, BURST_INCR, 3'd3, 1'b0);
      tick();
      rready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("r_stall_rvalid", rvalid, 1'b1);
         tick();
      end
      rready = 1'b1;
      drain();

      // B back-pressure for 3 cycles
      bready = 1'b0;
      axi_write(32'h30, 8'd0, BURST_INCR, 3'd3, 1'b1, 64'h55, 8'hFF, RESP_OKAY);
      for (int i = 0; i < 3; i++) begin
         check("b_stall_bvalid", bvalid, 1'b1);
         tick();
      end
      bready = 1'b1;
      drain();

      // FIXED burst: both beats hit the same word
      axi_write(32'h38, 8'd1, BURST_FIXED, 3'd3, 1'b0, 64'd7, 8'hFF, RESP_OKAY);
      drain();
      exp_r(64'd8, RESP_OKAY, 1'b0, 1'b0);
      exp_r(64'd8, RESP_OKAY, 1'b1, 1'b0);
      axi_read(32'h38, 8'd1, BURST_FIXED, 3'd3, 1'b0);
      drain();

      // WRAP read from 0x18 over a 32-byte window
`ifdef AXI_MEM_WRAP_EN
      exp_r(64'd2, RESP_OKAY, 1'b0, 1'b1);
      exp_r(64'hA0A0, RESP_OKAY, 1'b0, 1'b1);
      exp_r(64'h0000_0000_FFFF_FFFF, RESP_OKAY, 1'b0, 1'b1);
      exp_r(64'd1, RESP_OKAY, 1'b1, 1'b1);
`else
      for (int i = 0; i < 4; i++) exp_r(64'd0, RESP_SLVERR, i == 3, 1'b1);
`endif
      axi_read(32'h18, 8'd3, BURST_WRAP, 3'd3, 1'b1);
      drain();

      // Same-edge write and read of one word: read sees the old value
      axi_write(32'h40, 8'd0, BURST_INCR, 3'd3, 1'b0, 64'h1111, 8'hFF, RESP_OKAY);
      drain();
      b_q.push_back('{id: 1'b0, resp: RESP_OKAY});
      exp_r(64'h1111, RESP_OKAY, 1'b1, 1'b0);
      awaddr = 32'h40; awlen = 0; awsize = 3; awburst = BURST_INCR; awid = 0; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wdata = 64'h2222; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
      araddr = 32'h40; arlen = 0; arsize = 3; arburst = BURST_INCR; arid = 0; arvalid = 1'b1;
      tick();
      wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
      drain();
      exp_r(64'h2222, RESP_OKAY, 1'b1, 1'b0);
      axi_read(32'h40, 8'd0, BURST_INCR, 3'd3, 1'b0);
      drain();

      // Reset during beat 2 of a 4-beat write
      awaddr = 32'h50; awlen = 8'd3; awsize = 3; awburst = BURST_INCR; awid = 1; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wdata = 64'hB1; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      tick();
      wdata = 64'hB2;
      rst = 1'b1;
      tick();
      check("midrst_awready", awready, 1'b1);
      check("midrst_wready", wready, 1'b0);
      check("midrst_bvalid", bvalid, 1'b0);
      rst = 1'b0;
      wvalid = 1'b0;
      tick();
      exp_r(64'hB1, RESP_OKAY, 1'b1, 1'b0);
      axi_read(32'h50, 8'd0, BURST_INCR, 3'd3, 1'b0);
      drain();

      // 256-beat INCR burst
      axi_write(32'h100, 8'd255, BURST_INCR, 3'd3, 1'b1, 64'h1000, 8'hFF, RESP_OKAY);
      drain();
      for (int i = 0; i < 256; i++) exp_r(64'h1000 + 64'(i), RESP_OKAY, i == 255, 1'b1);
      axi_read(32'h100, 8'd255, BURST_INCR, 3'd3, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
